// File: rtl/veritune_mem_sched_if.sv
// Bus bundle between the sample-memory scheduler, its three requesters and the sample RAM.
// The master side is the surrounding system (recorder, playback, FFT and RAM); the slave side is the scheduler.
interface veritune_mem_sched_if #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DATA_W = 16
) ();
   logic              rec_req;
   logic [ADDR_W-1:0] rec_addr;
   logic [DATA_W-1:0] rec_data;
   logic              rec_ack;

   logic              play_req;
   logic [ADDR_W-1:0] play_addr;
   logic              play_ack;
   logic              play_valid;
   logic [DATA_W-1:0] play_data;

   logic              fft_start;
   logic [ADDR_W-1:0] fft_base;
   logic              fft_busy;
   logic              fft_done;
   logic [DATA_W-1:0] fft_x0;
   logic [DATA_W-1:0] fft_x1;
   logic [DATA_W-1:0] fft_x2;
   logic [DATA_W-1:0] fft_x3;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output rec_req, rec_addr, rec_data,
      input  rec_ack,
      output play_req, play_addr,
      input  play_ack, play_valid, play_data,
      output fft_start, fft_base,
      input  fft_busy, fft_done, fft_x0, fft_x1, fft_x2, fft_x3,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  rec_req, rec_addr, rec_data,
      output rec_ack,
      input  play_req, play_addr,
      output play_ack, play_valid, play_data,
      input  fft_start, fft_base,
      output fft_busy, fft_done, fft_x0, fft_x1, fft_x2, fft_x3,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/veritune_mem_sched.sv
// Single-port sample-memory scheduler: recorder writes, playback reads and a FRAME-sample FFT fetch,
// with starvation promotion of the FFT above playback.
module veritune_mem_sched #(
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FRAME      = 4,
   parameter int unsigned STARVE_MAX = 15
) (
   input logic                 Clk,
   input logic                 Reset,
   veritune_mem_sched_if.slave bus
);
   localparam int unsigned BEAT_W   = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
   localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(FRAME - 1);
   localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

   typedef enum logic [1:0] {F_IDLE, F_FETCH, F_DRAIN, F_DONE} fft_state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_PLAY, TAG_FFT} tag_kind_t;
   typedef enum logic [1:0] {G_NONE, G_REC, G_PLAY, G_FFT} grant_t;

   fft_state_t          state_q, state_d;
   grant_t              grant;
   tag_kind_t           tag_kind_q, tag_kind_d;
   logic [BEAT_W-1:0]   tag_beat_q, tag_beat_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   addr_q, mem_addr_c, fft_addr;
   logic [DATA_W-1:0]   wdata_q, mem_wdata_c;
   logic [DATA_W-1:0]   play_data_q;
   logic [DATA_W-1:0]   fft_x_q [FRAME];
   logic                fft_pend;

   assign fft_pend = (state_q == F_FETCH);
   assign fft_addr = base_q + ADDR_W'(beat_q);

   // Arbitration, FFT next-state and beat/starvation bookkeeping
   always_comb begin : sched_next
      grant      = G_NONE;
      state_d    = state_q;
      beat_d     = beat_q;
      base_d     = base_q;
      starve_d   = starve_q;
      tag_kind_d = TAG_NONE;
      tag_beat_d = beat_q;

      if (Reset)                                 grant = G_NONE;
      else if (bus.rec_req)                      grant = G_REC;
      else if (fft_pend && starve_q == STARVE_TOP) grant = G_FFT;
      else if (bus.play_req)                     grant = G_PLAY;
      else if (fft_pend)                         grant = G_FFT;

      case (grant)
         G_PLAY:  tag_kind_d = TAG_PLAY;
         G_FFT:   tag_kind_d = TAG_FFT;
         default: tag_kind_d = TAG_NONE;
      endcase

      if (fft_pend) begin
         if (grant == G_FFT)             starve_d = '0;
         else if (starve_q != STARVE_TOP) starve_d = STARVE_W'(starve_q + 1'b1);
      end

      case (state_q)
         F_IDLE: begin
            if (bus.fft_start) begin
               state_d = F_FETCH;
               base_d  = bus.fft_base;
               beat_d  = '0;
            end
         end
         F_FETCH: begin
            if (grant == G_FFT) begin
               beat_d = BEAT_W'(beat_q + 1'b1);
               if (beat_q == LAST_BEAT) state_d = F_DRAIN;
            end
         end
         F_DRAIN: state_d = F_DONE;
         F_DONE:  state_d = F_IDLE;
         default: state_d = F_IDLE;
      endcase
   end

   // Memory port mux; address and write data hold when nothing is granted
   always_comb begin : mem_mux
      mem_addr_c  = addr_q;
      mem_wdata_c = wdata_q;
      case (grant)
         G_REC: begin
            mem_addr_c  = bus.rec_addr;
            mem_wdata_c = bus.rec_data;
         end
         G_PLAY:  mem_addr_c = bus.play_addr;
         G_FFT:   mem_addr_c = fft_addr;
         default: mem_addr_c = addr_q;
      endcase
   end

   always_ff @(posedge Clk) begin : state_reg
      if (Reset) state_q <= F_IDLE;
      else       state_q <= state_d;
   end

   // Datapath registers; the read tag steers the returning sample one cycle after the grant
   always_ff @(posedge Clk) begin : data_reg
      if (Reset) begin
         beat_q      <= '0;
         starve_q    <= '0;
         base_q      <= '0;
         tag_kind_q  <= TAG_NONE;
         tag_beat_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         play_data_q <= '0;
         for (int i = 0; i < FRAME; i++) fft_x_q[i] <= '0;
      end else begin
         beat_q     <= beat_d;
         starve_q   <= starve_d;
         base_q     <= base_d;
         tag_kind_q <= tag_kind_d;
         tag_beat_q <= tag_beat_d;
         addr_q     <= mem_addr_c;
         wdata_q    <= mem_wdata_c;
         if (tag_kind_q == TAG_PLAY) play_data_q <= bus.mem_rdata;
         if (tag_kind_q == TAG_FFT)  fft_x_q[tag_beat_q] <= bus.mem_rdata;
      end
   end

   assign bus.rec_ack    = (grant == G_REC);
   assign bus.play_ack   = (grant == G_PLAY);
   assign bus.mem_we     = (grant == G_REC);
   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_wdata  = mem_wdata_c;
   assign bus.play_valid = (tag_kind_q == TAG_PLAY);
   assign bus.play_data  = (tag_kind_q == TAG_PLAY) ? bus.mem_rdata : play_data_q;
   assign bus.fft_busy   = (state_q == F_FETCH) || (state_q == F_DRAIN);
   assign bus.fft_done   = (state_q == F_DONE);
   assign bus.fft_x0     = fft_x_q[0];
   assign bus.fft_x1     = fft_x_q[1];
   assign bus.fft_x2     = fft_x_q[2];
   assign bus.fft_x3     = fft_x_q[3];
endmodule

// File: tb/tb_veritune_mem_sched.sv
// Bench for veritune_mem_sched: directed steps plus random traffic checked against a cycle-level
// behavioural model of the arbitration rules, the sample memory and the frame fetch.
module tb_veritune_mem_sched;
   localparam int ADDR_W     = 17;
   localparam int DATA_W     = 16;
   localparam int FRAME      = 4;
   localparam int STARVE_MAX = 15;

   typedef enum int {G_NONE, G_REC, G_PLAY, G_FFT} gsel_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   veritune_mem_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   veritune_mem_sched #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME(FRAME), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .Clk(clk),
      .Reset(rst),
      .bus(bus)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [15:0] ram     [logic [16:0]];
   logic [15:0] ref_mem [logic [16:0]];

   // Reference model state
   bit          m_fetching;
   int          m_beats, m_lost, m_done_cycle;
   logic [16:0] m_base, m_last_addr;
   bit          m_play_pend;
   logic [15:0] m_play_exp, m_last_play;
   logic [15:0] m_exp_x [4];
   gsel_t       last_g;

   bit          r_req, p_req;
   logic [16:0] r_addr, p_addr;
   logic [15:0] r_data;

   function automatic logic [15:0] ram_rd(input logic [16:0] a);
      return ram.exists(a) ? ram[a] : 16'h0;
   endfunction

   function automatic logic [15:0] ref_rd(input logic [16:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fetching   = 1'b0;
      m_beats      = 0;
      m_lost       = 0;
      m_done_cycle = -1;
      m_base       = '0;
      m_last_addr  = '0;
      m_play_pend  = 1'b0;
      m_play_exp   = '0;
      m_last_play  = '0;
      for (int k = 0; k < 4; k++) m_exp_x[k] = '0;
   endtask

   task automatic preload(input logic [16:0] a, input logic [15:0] d);
      ram[a]     = d;
      ref_mem[a] = d;
   endtask

   function automatic gsel_t exp_grant();
      if (rst)                                   return G_NONE;
      if (bus.rec_req)                           return G_REC;
      if (m_fetching && m_lost >= STARVE_MAX)    return G_FFT;
      if (bus.play_req)                          return G_PLAY;
      if (m_fetching)                            return G_FFT;
      return G_NONE;
   endfunction

   // One clock: check combinational and registered outputs mid-cycle, advance model, act as the RAM
   task automatic tick();
      gsel_t       g;
      logic [16:0] ea, wa;
      logic [15:0] wd, nrd;
      logic        we;
      bit          busy_e;
      #1;
      we  = bus.mem_we;
      wa  = bus.mem_addr;
      wd  = bus.mem_wdata;
      nrd = ram_rd(wa);
      g   = exp_grant();
      last_g = g;
      chk("rec_ack",  32'(bus.rec_ack),  32'(g == G_REC));
      chk("play_ack", 32'(bus.play_ack), 32'(g == G_PLAY));
      chk("mem_we",   32'(we),           32'(g == G_REC));
      if (!rst) begin
         case (g)
            G_REC:   ea = bus.rec_addr;
            G_PLAY:  ea = bus.play_addr;
            G_FFT:   ea = 17'((int'(m_base) + m_beats) % (1 << ADDR_W));
            default: ea = m_last_addr;
         endcase
         chk("mem_addr", 32'(wa), 32'(ea));
         if (g == G_REC) chk("mem_wdata", 32'(wd), 32'(bus.rec_data));
         chk("play_valid", 32'(bus.play_valid), 32'(m_play_pend));
         chk("play_data",  32'(bus.play_data),  32'(m_play_pend ? m_play_exp : m_last_play));
         busy_e = m_fetching || (m_done_cycle >= 0 && cyc < m_done_cycle);
         chk("fft_busy", 32'(bus.fft_busy), 32'(busy_e));
         chk("fft_done", 32'(bus.fft_done), 32'(cyc == m_done_cycle));
         if (cyc == m_done_cycle) begin
            chk("fft_x0", 32'(bus.fft_x0), 32'(m_exp_x[0]));
            chk("fft_x1", 32'(bus.fft_x1), 32'(m_exp_x[1]));
            chk("fft_x2", 32'(bus.fft_x2), 32'(m_exp_x[2]));
            chk("fft_x3", 32'(bus.fft_x3), 32'(m_exp_x[3]));
         end

         if (m_play_pend) m_last_play = m_play_exp;
         m_play_pend = (g == G_PLAY);
         if (g != G_NONE) m_last_addr = ea;
         case (g)
            G_REC:  ref_mem[ea] = bus.rec_data;
            G_PLAY: m_play_exp = ref_rd(ea);
            G_FFT: begin
               m_exp_x[m_beats] = ref_rd(ea);
               m_beats++;
               m_lost = 0;
               if (m_beats == FRAME) begin
                  m_fetching   = 1'b0;
                  m_done_cycle = cyc + 2;
               end
            end
            default: ;
         endcase
         if (m_fetching && g != G_FFT && m_lost < STARVE_MAX) m_lost++;
         if (cyc == m_done_cycle) m_done_cycle = -1;
         else if (bus.fft_start && !m_fetching && m_done_cycle < 0) begin
            m_fetching = 1'b1;
            m_base     = bus.fft_base;
            m_beats    = 0;
            m_lost     = 0;
         end
      end
      @(posedge clk);
      if (we) ram[wa] = wd;
      if (rst) model_reset();
      #1 bus.mem_rdata = nrd;
      cyc++;
      @(negedge clk);
   endtask

   task automatic drive(input bit rr, input logic [16:0] ra, input logic [15:0] rd,
                        input bit pr, input logic [16:0] pa, input bit fs, input logic [16:0] fb);
      bus.rec_req   = rr;
      bus.rec_addr  = ra;
      bus.rec_data  = rd;
      bus.play_req  = pr;
      bus.play_addr = pa;
      bus.fft_start = fs;
      bus.fft_base  = fb;
      tick();
      bus.fft_start = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   // Requesters that hold request/address/data until the model says they were granted
   task automatic req_tick();
      bus.rec_req   = r_req;
      bus.rec_addr  = r_addr;
      bus.rec_data  = r_data;
      bus.play_req  = p_req;
      bus.play_addr = p_addr;
      tick();
      bus.fft_start = 1'b0;
      if (last_g == G_REC)  r_req = 1'b0;
      if (last_g == G_PLAY) p_req = 1'b0;
   endtask

   function automatic logic [16:0] rand_addr();
      if ($urandom_range(0, 1) == 0) return 17'($urandom_range(0, 31));
      return 17'(17'h1FFE0 + 17'($urandom_range(0, 31)));
   endfunction

   task automatic chk_frame(input string t, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
      chk({t, "_x0"}, 32'(bus.fft_x0), 32'(a));
      chk({t, "_x1"}, 32'(bus.fft_x1), 32'(b));
      chk({t, "_x2"}, 32'(bus.fft_x2), 32'(c));
      chk({t, "_x3"}, 32'(bus.fft_x3), 32'(d));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1'b1;
      bus.rec_req = 1'b0; bus.rec_addr = '0; bus.rec_data = '0;
      bus.play_req = 1'b0; bus.play_addr = '0;
      bus.fft_start = 1'b0; bus.fft_base = '0;
      bus.mem_rdata = '0;
      r_req = 1'b0; p_req = 1'b0; r_addr = '0; p_addr = '0; r_data = '0;
      model_reset();
      @(negedge clk);

      // Reset, then ten quiet cycles
      idle(); idle();
      rst = 1'b0;
      chk("rst_mem_addr",  32'(bus.mem_addr),  32'(0));
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
      chk_frame("rst", 16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < 10; i++) idle();

      // Write then read back the same address
      drive(1'b1, 17'd5, 16'h1234, 1'b0, '0, 1'b0, '0);
      drive(1'b0, '0, '0, 1'b1, 17'd5, 1'b0, '0);
      chk("wr_rd_valid", 32'(bus.play_valid), 32'(1));
      chk("wr_rd_data",  32'(bus.play_data),  32'(16'h1234));
      idle(); idle();

      // Recorder outranks playback while both are held
      for (int i = 0; i < 3; i++) drive(1'b1, 17'(10 + i), 16'(16'h0100 + i), 1'b1, 17'd5, 1'b0, '0);
      drive(1'b0, '0, '0, 1'b1, 17'd5, 1'b0, '0);
      idle(); idle();

      // Uncontended frame fetch across the address wrap; a start while busy is ignored
      preload(17'h1FFFE, 16'h000A);
      preload(17'h1FFFF, 16'h000B);
      preload(17'h00000, 16'h000C);
      preload(17'h00001, 16'h000D);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 17'h1FFFE);
      idle();
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 17'h00100);
      idle(); idle(); idle();
      chk("wrap_done", 32'(bus.fft_done), 32'(1));
      chk("wrap_busy", 32'(bus.fft_busy), 32'(0));
      chk_frame("wrap", 16'h000A, 16'h000B, 16'h000C, 16'h000D);
      idle();
      chk("wrap_no_restart", 32'(bus.fft_busy), 32'(0));
      idle();

      // FFT against continuous playback with occasional recorder traffic
      for (int i = 0; i < 8; i++) preload(17'(17'h40 + i), 16'($urandom));
      p_req = 1'b1; p_addr = rand_addr();
      bus.fft_start = 1'b1; bus.fft_base = 17'h40;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (!p_req) begin p_req = 1'b1; p_addr = rand_addr(); end
         if (!r_req && $urandom_range(0, 7) == 0) begin
            r_req = 1'b1; r_addr = rand_addr(); r_data = 16'($urandom);
         end
         req_tick();
         if (bus.fft_done) seen = 1'b1;
      end
      chk("starve_done_seen", 32'(seen), 32'(1));
      p_req = 1'b0;
      for (int i = 0; i < 4; i++) req_tick();

      // Reset in the middle of a fetch abandons the frame
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 17'h1FFFE);
      idle(); idle();
      rst = 1'b1;
      idle();
      rst = 1'b0;
      chk("midrst_busy", 32'(bus.fft_busy), 32'(0));
      chk_frame("midrst", 16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < 4; i++) idle();
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 17'h1FFFE);
      for (int i = 0; i < 5; i++) idle();
      chk("refetch_done", 32'(bus.fft_done), 32'(1));
      chk_frame("refetch", 16'h000A, 16'h000B, 16'h000C, 16'h000D);
      idle();

      // Random mixed traffic
      for (int i = 0; i < 400; i++) begin
         if (!r_req && $urandom_range(0, 2) == 0) begin
            r_req = 1'b1; r_addr = rand_addr(); r_data = 16'($urandom);
         end
         if (!p_req && $urandom_range(0, 2) == 0) begin
            p_req = 1'b1; p_addr = rand_addr();
         end
         if ($urandom_range(0, 11) == 0) begin
            bus.fft_start = 1'b1; bus.fft_base = rand_addr();
         end
         req_tick();
      end
      r_req = 1'b0; p_req = 1'b0;
      for (int i = 0; i < 80; i++) req_tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
